// File: rtl/rr_lock_arbiter_pkg.sv
// rtl/rr_lock_arbiter_pkg.sv - shared types and helpers for the round-robin locking arbiter
//
// Contents:
//   arb_state_e      arbiter FSM state (IDLE: no owner, GRANT: resource locked to one requester)
//   MAX_REQ          widest request vector onehot_to_idx() accepts
//   onehot_to_idx()  index of the set bit in a one-hot vector (0 when the vector is empty)

package rr_lock_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_REQ = 32;

    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_arbiter_msb_to_lsb.sv
// rtl/prio_arbiter_msb_to_lsb.sv - combinational fixed-priority picker, highest index wins
//
// Ports:
//   req  in   SIZE  request vector
//   gnt  out  SIZE  one-hot of the highest set bit of req; 0 when req is 0

module prio_arbiter_msb_to_lsb #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] req,
    output logic [SIZE-1:0] gnt
);

    // Ascending scan: each later (higher) set bit overrides any earlier pick.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - round-robin packet-locking arbiter for one shared beat-based resource
//
// Parameters:
//   SIZE        number of requesters (>= 2, <= 32)
//   MAX_HOLD    beats allowed per grant before a forced release; 0 = unlimited
// Ports:
//   clk         in   1             clock, posedge
//   rst_n       in   1             synchronous active-low reset
//   req         in   SIZE          requester i has a pending beat
//   last        in   SIZE          requester i's current beat ends its packet
//   rsrc_ready  in   1             resource accepts a beat this cycle
//   gnt         out  SIZE          registered one-hot grant, 0 when idle
//   gnt_id      out  log2(SIZE)    index of the granted requester, 0 when idle
//   gnt_valid   out  1             a grant is active
//   xfer        out  1             a beat moves this cycle

module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int MAX_HOLD = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SIZE-1:0]         req,
    input  logic [SIZE-1:0]         last,
    input  logic                    rsrc_ready,
    output logic [SIZE-1:0]         gnt,
    output logic [$clog2(SIZE)-1:0] gnt_id,
    output logic                    gnt_valid,
    output logic                    xfer
);

    localparam int IDW = $clog2(SIZE);
    localparam int BCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [BCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : BCW'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [SIZE-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [SIZE-1:0]  mask;
    logic [SIZE-1:0]  req_m;
    logic [SIZE-1:0]  cand_m;
    logic [SIZE-1:0]  cand_u;
    logic [SIZE-1:0]  winner;
    logic [IDW-1:0]   winner_id;
    logic             req_g;
    logic             last_g;
    logic             hold_hit;
    logic             release_now;

    // Only indices below the last released owner are eligible first, so the
    // search resumes at ptr-1 and descends; falling back to the unmasked pick
    // is the wrap to SIZE-1.
    always_comb begin
        mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            mask[i] = (IDW'(i) < ptr_q);
        end
    end

    assign req_m = req & mask;

    prio_arbiter_msb_to_lsb #(.SIZE(SIZE)) u_prio_masked (
        .req (req_m),
        .gnt (cand_m)
    );

    prio_arbiter_msb_to_lsb #(.SIZE(SIZE)) u_prio_unmasked (
        .req (req),
        .gnt (cand_u)
    );

    assign winner    = (|req_m) ? cand_m : cand_u;
    assign winner_id = IDW'(onehot_to_idx(MAX_REQ'(winner)));

    assign req_g  = req[gnt_id_q];
    assign last_g = last[gnt_id_q];
    assign xfer   = gnt_valid_q & rsrc_ready & req_g;

    assign hold_hit    = (MAX_HOLD != 0) && (beat_cnt_q == HOLD_LAST);
    // End of packet, hold limit reached, or owner dropped its request.
    assign release_now = (xfer & last_g) | (xfer & hold_hit) | ~req_g;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    gnt_d       = winner;
                    gnt_id_d    = winner_id;
                    gnt_valid_d = 1'b1;
                    beat_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q;
                end else if (xfer && (beat_cnt_q != '1)) begin
                    // Saturates when unlimited so a long packet never wraps it.
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_valid:   assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
    a_gnt_id:      assert property (@(posedge clk) disable iff (!rst_n)
                                    gnt == (SIZE'(gnt_valid) << gnt_id));

endmodule
